// File: rtl/fifo_wptr_ctrl.sv
// fifo_wptr_ctrl: write-side pointer, flag and fill-level controller for a dual-pointer FIFO
module fifo_wptr_ctrl #(
    parameter int ADDR_W    = 3,
    parameter int AFULL_THR = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              winc,
    input  logic              clr_ovf,
    input  logic [ADDR_W:0]   rq2_rptr_gray,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              wfull,
    output logic              walmost_full,
    output logic [ADDR_W:0]   wlevel,
    output logic              woverflow,
    output logic [1:0]        wstate
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE = 2'b00, FILL = 2'b01, AFULL = 2'b10, FULL = 2'b11} state_t;

    logic [ADDR_W:0] wbin, wbin_nxt, rbin, lvl_nxt;
    state_t          state, state_nxt;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ADDR_W; i++) rbin[i] = ^(rq2_rptr_gray >> i);
    end

    assign wen      = winc & ~wfull & ~rst;
    assign wbin_nxt = wbin + (ADDR_W+1)'(wen);
    assign lvl_nxt  = wbin_nxt - rbin;
    assign waddr    = wbin[ADDR_W-1:0];
    assign wstate   = state;

    // Fill-state decode from the occupancy the next edge will register
    always_comb begin
        state_nxt = lvl_nxt == '0 ? IDLE :
                    lvl_nxt < (ADDR_W+1)'(AFULL_THR) ? FILL :
                    lvl_nxt < (ADDR_W+1)'(DEPTH) ? AFULL : FULL;
    end

    // Pointer, flag, level and fill-state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wbin         <= '0;
            wptr_gray    <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            woverflow    <= 1'b0;
            state        <= IDLE;
        end else begin
            wbin         <= wbin_nxt;
            wptr_gray    <= wbin_nxt ^ (wbin_nxt >> 1);
            wfull        <= lvl_nxt >= (ADDR_W+1)'(DEPTH);
            walmost_full <= lvl_nxt >= (ADDR_W+1)'(AFULL_THR);
            wlevel       <= lvl_nxt;
            woverflow    <= (winc & wfull) | (woverflow & ~clr_ovf);
            state        <= state_nxt;
        end
    end
endmodule
